mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Memory-stage load/store unit for the 5-stage pipeline. It sits between the EX/MEM pipeline register and the MEM/WB register. It drives the data-memory request handshake, aligns store data and byte enables, and extracts and sign- or zero-extends load data. It then registers the MEM/WB fields (DataMemOut, ALUResult, MemToReg, RegWrite, write register) that the writeback select consumes. It stalls upstream stages while a memory access is outstanding.

## Interface
Parameters: none (32-bit datapath, 5-bit register index fixed).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- exValid  in  1  EX/MEM holds a valid instruction
- ALUResult  in  32  effective address, or result for non-memory ops
- storeData  in  32  rt value for stores (data in low bits)
- MemRead  in  1  load
- MemWrite  in  1  store
- MemToReg  in  1  writeback select, passed through
- RegWrite  in  1  register write enable, passed through
- writeReg  in  5  destination register, passed through
- size  in  2  00 byte, 01 half, 10 word; 11 is treated as word
- unsignedLoad  in  1  zero-extend instead of sign-extend
- memReq  out  1  data-memory request, held until ack
- memWe  out  1  1 = write
- memAddr  out  32  word address, {ALUResult[31:2],2'b00}
- memWData  out  32  lane-replicated store data
- memByteEn  out  4  active byte lanes
- memAck  in  1  one-cycle completion from memory
- memRData  in  32  read word, valid with memAck
- stallMem  out  1  upstream must hold EX/MEM contents
- misalignErr  out  1  one-cycle pulse on a misaligned access
- wbValid, wbDataMemOut[31:0], wbALUResult[31:0], wbMemToReg, wbRegWrite, wbWriteReg[4:0]  out  registered MEM/WB fields

## Operation
- There are two states: IDLE and ACCESS.
- **IDLE, no memory op** (exValid and neither MemRead nor MemWrite): MEM/WB loads the inputs next edge with wbValid=1 and wbDataMemOut=0. No stall.
- **IDLE, exValid=0:** wbValid=0 and wbRegWrite=0 next edge (bubble).
- **IDLE, memory op, aligned:** go to ACCESS. Latch address, write flag, memWData, memByteEn, size, unsignedLoad and the passthrough fields. stallMem=1 combinationally this cycle. MEM/WB gets a bubble.
- **Misalignment:** half with addr[0]=1, or word with addr[1:0]≠0. No request is made. The next edge loads MEM/WB with wbValid=1 and wbRegWrite=0, and misalignErr pulses high for that one cycle. No stall.
- **MemRead and MemWrite both set:** treated as a store.
- **ACCESS:** memReq=1 with stable latched address and data. stallMem = !memAck.
  - On memAck: the next edge loads MEM/WB with wbValid=1 and returns to IDLE. For loads, wbDataMemOut is the extracted load data; for stores it is 0.
  - In the ack cycle, stallMem=0, so upstream advances and the new EX/MEM contents are evaluated from IDLE on the following cycle.
- **Store lanes:**
  - Byte: memWData={4{storeData[7:0]}}, memByteEn=4'b0001<<addr[1:0].
  - Half: memWData={2{storeData[15:0]}}, memByteEn = addr[1] ? 4'b1100 : 4'b0011.
  - Word: memWData=storeData, memByteEn=4'b1111.
- **Loads:** memByteEn is driven as for stores. memWData=0.
- **Load extract:** byte = memRData[8*addr[1:0]+:8]; half = memRData[16*addr[1]+:16]. Sign-extend from bit 7/15 unless unsignedLoad, in which case zero-extend. Word is passed unchanged.
- memAck while in IDLE is ignored.

## Timing
- Reset (async, rst_n=0):
  - State IDLE.
  - memReq=0, memWe=0, memAddr=0, memWData=0, memByteEn=0.
  - misalignErr=0, all wb* outputs 0.
  - stallMem is 0 while reset is held.
- Reset mid-ACCESS drops memReq immediately, and the access is abandoned.
- Non-memory op latency: 1 cycle to MEM/WB.
- Memory op latency: 1 request-setup cycle plus N≥1 ACCESS cycles. With memAck in the first ACCESS cycle, the op occupies 2 cycles and MEM/WB loads at the end of the second.
- memReq is registered (asserted from the first ACCESS cycle) and deasserts on the edge after memAck.
- stallMem is combinational, from state, inputs and memAck.

## Test plan
- **Reset:** hold rst_n=0 with memory-op inputs active → all outputs 0. Release → first aligned load issues memReq one cycle later.
- **Non-memory op:** ALUResult=0x00000042, RegWrite=1, writeReg=5, MemToReg=0 → next cycle wbValid=1, wbALUResult=0x42, wbWriteReg=5. stallMem never asserted.
- **Signed byte load, 2-cycle ack:**
  - Stimulus: addr 0x103, memRData=0x80FFFFFF, memAck delayed 2 cycles.
  - Required: memAddr=0x100, memByteEn=0001<<3 (=1000), stallMem high 3 cycles, wbDataMemOut=0xFFFFFF80.
  - Repeat with unsignedLoad=1 → 0x00000080.
- **Half store:** addr 0x202, storeData=0x1234ABCD → memWData=0xABCDABCD, memByteEn=1100, memWe=1, wbDataMemOut=0.
- **Misalignment:** word load at 0x101 → no memReq, misalignErr one-cycle pulse, wbValid=1, wbRegWrite=0.
- **Back-to-back with reset mid-op:**
  - Two consecutive loads, ack in the first ACCESS cycle → each op takes 2 cycles, with the second issue on the cycle after the first op's ack cycle.
  - Assert rst_n=0 during ACCESS → memReq drops immediately, no MEM/WB update.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: drives the data-memory handshake, aligns store lanes,
// extracts load data and registers the MEM/WB fields consumed by writeback.
module mem_stage_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exValid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] storeData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemToReg,
    input  logic        RegWrite,
    input  logic [4:0]  writeReg,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    output logic [3:0]  memByteEn,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        stallMem,
    output logic        misalignErr,
    output logic        wbValid,
    output logic [31:0] wbDataMemOut,
    output logic [31:0] wbALUResult,
    output logic        wbMemToReg,
    output logic        wbRegWrite,
    output logic [4:0]  wbWriteReg
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } lsuState_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    function automatic logic isMisaligned(input logic [1:0] sz, input logic [1:0] a);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = a[0];
            default: bad = (a != 2'b00);
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] laneEnable(input logic [1:0] sz, input logic [1:0] a);
        logic [3:0] be;
        case (sz)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] laneData(input logic [1:0] sz, input logic [31:0] d);
        logic [31:0] w;
        case (sz)
            SZ_BYTE: w = {4{d[7:0]}};
            SZ_HALF: w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] loadExtract(input logic [1:0] sz, input logic [1:0] a,
                                                input logic uns, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rd[{a, 3'b000} +: 8];
        h = rd[{a[1], 4'b0000} +: 16];
        case (sz)
            SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    lsuState_t   state_r;
    lsuState_t   nextState_s;
    logic [1:0]  addrLow_r;
    logic [1:0]  size_r;
    logic        uns_r;
    logic [31:0] aluRes_r;
    logic        memToReg_r;
    logic        regWrite_r;
    logic [4:0]  writeReg_r;
    logic        latchEn_s;

    logic        memReqNxt_s;
    logic        memWeNxt_s;
    logic [31:0] memAddrNxt_s;
    logic [31:0] memWDataNxt_s;
    logic [3:0]  memByteEnNxt_s;
    logic        misalignNxt_s;
    logic        wbValidNxt_s;
    logic [31:0] wbDataNxt_s;
    logic [31:0] wbAluNxt_s;
    logic        wbMemToRegNxt_s;
    logic        wbRegWriteNxt_s;
    logic [4:0]  wbWriteRegNxt_s;
    logic        isMemOp_s;

    assign isMemOp_s = MemRead | MemWrite;

    // Next-state, stall and next values for every registered output.
    always_comb begin
        nextState_s     = state_r;
        stallMem        = 1'b0;
        latchEn_s       = 1'b0;
        memReqNxt_s     = memReq;
        memWeNxt_s      = memWe;
        memAddrNxt_s    = memAddr;
        memWDataNxt_s   = memWData;
        memByteEnNxt_s  = memByteEn;
        misalignNxt_s   = 1'b0;
        wbValidNxt_s    = 1'b0;
        wbRegWriteNxt_s = 1'b0;
        wbDataNxt_s     = wbDataMemOut;
        wbAluNxt_s      = wbALUResult;
        wbMemToRegNxt_s = wbMemToReg;
        wbWriteRegNxt_s = wbWriteReg;
        case (state_r)
            IDLE: begin
                if (exValid && isMemOp_s) begin
                    if (isMisaligned(size, ALUResult[1:0])) begin
                        misalignNxt_s   = 1'b1;
                        wbValidNxt_s    = 1'b1;
                        wbDataNxt_s     = 32'h0000_0000;
                        wbAluNxt_s      = ALUResult;
                        wbMemToRegNxt_s = MemToReg;
                        wbWriteRegNxt_s = writeReg;
                    end else begin
                        // rst_n gate keeps the stall quiet while reset is held
                        stallMem       = rst_n;
                        nextState_s    = ACCESS;
                        latchEn_s      = 1'b1;
                        memReqNxt_s    = 1'b1;
                        memWeNxt_s     = MemWrite;
                        memAddrNxt_s   = {ALUResult[31:2], 2'b00};
                        memWDataNxt_s  = MemWrite ? laneData(size, storeData) : 32'h0000_0000;
                        memByteEnNxt_s = laneEnable(size, ALUResult[1:0]);
                    end
                end else if (exValid) begin
                    wbValidNxt_s    = 1'b1;
                    wbRegWriteNxt_s = RegWrite;
                    wbDataNxt_s     = 32'h0000_0000;
                    wbAluNxt_s      = ALUResult;
                    wbMemToRegNxt_s = MemToReg;
                    wbWriteRegNxt_s = writeReg;
                end else begin
                    wbValidNxt_s = 1'b0;
                end
            end
            ACCESS: begin
                if (memAck) begin
                    nextState_s     = IDLE;
                    memReqNxt_s     = 1'b0;
                    memWeNxt_s      = 1'b0;
                    wbValidNxt_s    = 1'b1;
                    wbRegWriteNxt_s = regWrite_r;
                    wbDataNxt_s     = memWe ? 32'h0000_0000
                                            : loadExtract(size_r, addrLow_r, uns_r, memRData);
                    wbAluNxt_s      = aluRes_r;
                    wbMemToRegNxt_s = memToReg_r;
                    wbWriteRegNxt_s = writeReg_r;
                end else begin
                    stallMem = 1'b1;
                end
            end
            default: begin
                nextState_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Access context captured at issue for use when the ack arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrLow_r  <= 2'b00;
            size_r     <= 2'b00;
            uns_r      <= 1'b0;
            aluRes_r   <= 32'h0000_0000;
            memToReg_r <= 1'b0;
            regWrite_r <= 1'b0;
            writeReg_r <= 5'd0;
        end else if (latchEn_s) begin
            addrLow_r  <= ALUResult[1:0];
            size_r     <= size;
            uns_r      <= unsignedLoad;
            aluRes_r   <= ALUResult;
            memToReg_r <= MemToReg;
            regWrite_r <= RegWrite;
            writeReg_r <= writeReg;
        end
    end

    // Memory request and MEM/WB output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memReq       <= 1'b0;
            memWe        <= 1'b0;
            memAddr      <= 32'h0000_0000;
            memWData     <= 32'h0000_0000;
            memByteEn    <= 4'b0000;
            misalignErr  <= 1'b0;
            wbValid      <= 1'b0;
            wbDataMemOut <= 32'h0000_0000;
            wbALUResult  <= 32'h0000_0000;
            wbMemToReg   <= 1'b0;
            wbRegWrite   <= 1'b0;
            wbWriteReg   <= 5'd0;
        end else begin
            memReq       <= memReqNxt_s;
            memWe        <= memWeNxt_s;
            memAddr      <= memAddrNxt_s;
            memWData     <= memWDataNxt_s;
            memByteEn    <= memByteEnNxt_s;
            misalignErr  <= misalignNxt_s;
            wbValid      <= wbValidNxt_s;
            wbDataMemOut <= wbDataNxt_s;
            wbALUResult  <= wbAluNxt_s;
            wbMemToReg   <= wbMemToRegNxt_s;
            wbRegWrite   <= wbRegWriteNxt_s;
            wbWriteReg   <= wbWriteRegNxt_s;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed, table-driven bench for mem_stage_lsu with hand-computed expectations.
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exValid, MemRead, MemWrite, MemToReg, RegWrite, unsignedLoad, memAck;
    logic [31:0] ALUResult, storeData, memRData;
    logic [4:0]  writeReg;
    logic [1:0]  size;
    logic        memReq, memWe, stallMem, misalignErr, wbValid, wbMemToReg, wbRegWrite;
    logic [31:0] memAddr, memWData, wbDataMemOut, wbALUResult;
    logic [3:0]  memByteEn;
    logic [4:0]  wbWriteReg;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst_n(rst_n), .exValid(exValid), .ALUResult(ALUResult),
        .storeData(storeData), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .writeReg(writeReg), .size(size),
        .unsignedLoad(unsignedLoad), .memReq(memReq), .memWe(memWe), .memAddr(memAddr),
        .memWData(memWData), .memByteEn(memByteEn), .memAck(memAck), .memRData(memRData),
        .stallMem(stallMem), .misalignErr(misalignErr), .wbValid(wbValid),
        .wbDataMemOut(wbDataMemOut), .wbALUResult(wbALUResult), .wbMemToReg(wbMemToReg),
        .wbRegWrite(wbRegWrite), .wbWriteReg(wbWriteReg)
    );

    typedef struct packed {
        logic        ex;
        logic [31:0] alu;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        rw;
        logic [4:0]  wreg;
        logic        m2r;
        logic        ack;
        logic        eValid;
        logic        eRegWrite;
        logic        eMis;
        logic        eFields;
    } idleVec_t;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic        rw;
        logic [1:0]  dly;
        logic [31:0] eAddr;
        logic [31:0] eWData;
        logic [3:0]  eBe;
        logic        eWe;
        logic [31:0] eWb;
    } memVec_t;

    idleVec_t iv [6];
    memVec_t  mv [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearInputs();
        exValid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemToReg = 1'b0; RegWrite = 1'b0;
        unsignedLoad = 1'b0; memAck = 1'b0; ALUResult = 32'h0; storeData = 32'h0;
        memRData = 32'h0; writeReg = 5'd0; size = 2'b00;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ex alu rd wr sz rw wreg m2r ack | eValid eRegWrite eMis eFields
        iv[0] = '{1'b1, 32'h0000_0042, 1'b0, 1'b0, 2'b10, 1'b1, 5'd5,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        iv[1] = '{1'b0, 32'h1234_5678, 1'b1, 1'b0, 2'b10, 1'b1, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        iv[2] = '{1'b1, 32'h0000_0101, 1'b1, 1'b0, 2'b10, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        iv[3] = '{1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 2'b00, 1'b1, 5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        iv[4] = '{1'b1, 32'h0000_0203, 1'b0, 1'b1, 2'b01, 1'b0, 5'd2,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        iv[5] = '{1'b1, 32'h0000_0102, 1'b1, 1'b0, 2'b11, 1'b1, 5'd4,  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // alu sdata rdata rd wr sz uns rw dly | eAddr eWData eBe eWe eWb
        mv[0] = '{32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'd2,
                  32'h0000_0100, 32'h0, 4'b1000, 1'b0, 32'hFFFF_FF80};
        mv[1] = '{32'h0000_0103, 32'h0, 32'h80FF_FFFF, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 2'd2,
                  32'h0000_0100, 32'h0, 4'b1000, 1'b0, 32'h0000_0080};
        mv[2] = '{32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'd0,
                  32'h0000_0200, 32'hABCD_ABCD, 4'b1100, 1'b1, 32'h0};
        mv[3] = '{32'h0000_0300, 32'h0, 32'hDEAD_BEEF, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 2'd1,
                  32'h0000_0300, 32'h0, 4'b1111, 1'b0, 32'hDEAD_BEEF};
        mv[4] = '{32'h0000_0402, 32'h0, 32'h8001_7FFF, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, 2'd0,
                  32'h0000_0400, 32'h0, 4'b1100, 1'b0, 32'hFFFF_8001};
        mv[5] = '{32'h0000_0400, 32'h0, 32'h8001_F00F, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 2'd0,
                  32'h0000_0400, 32'h0, 4'b0011, 1'b0, 32'h0000_F00F};
        mv[6] = '{32'h0000_0501, 32'h0000_00A5, 32'h0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'd1,
                  32'h0000_0500, 32'hA5A5_A5A5, 4'b0010, 1'b1, 32'h0};
        mv[7] = '{32'h0000_0600, 32'h1122_3344, 32'h5555_5555, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 2'd0,
                  32'h0000_0600, 32'h1122_3344, 4'b1111, 1'b1, 32'h0};
        mv[8] = '{32'h0000_0704, 32'h0, 32'h0102_0304, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 2'd0,
                  32'h0000_0704, 32'h0, 4'b1111, 1'b0, 32'h0102_0304};
        mv[9] = '{32'h0000_0102, 32'h0, 32'h0045_0000, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 2'd3,
                  32'h0000_0100, 32'h0, 4'b0100, 1'b0, 32'h0000_0045};
    end

    initial begin
        clearInputs();
        // Reset held with an aligned load presented.
        exValid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; size = 2'b10;
        ALUResult = 32'h0000_0010; writeReg = 5'd6;
        tick(); tick();
        chk("rst_memReq", 32'(memReq), 32'h0);
        chk("rst_memWe", 32'(memWe), 32'h0);
        chk("rst_memAddr", memAddr, 32'h0);
        chk("rst_memWData", memWData, 32'h0);
        chk("rst_memByteEn", 32'(memByteEn), 32'h0);
        chk("rst_misalign", 32'(misalignErr), 32'h0);
        chk("rst_stall", 32'(stallMem), 32'h0);
        chk("rst_wbValid", 32'(wbValid), 32'h0);
        chk("rst_wbData", wbDataMemOut, 32'h0);
        chk("rst_wbAlu", wbALUResult, 32'h0);
        chk("rst_wbRegWrite", 32'(wbRegWrite), 32'h0);
        chk("rst_wbWriteReg", 32'(wbWriteReg), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("rel_stall", 32'(stallMem), 32'h1);
        chk("rel_memReq_pre", 32'(memReq), 32'h0);
        tick();
        chk("rel_memReq", 32'(memReq), 32'h1);
        chk("rel_memAddr", memAddr, 32'h0000_0010);
        memAck = 1'b1; memRData = 32'h1234_5678;
        tick();
        clearInputs();
        chk("rel_wbData", wbDataMemOut, 32'h1234_5678);
        chk("rel_wbWriteReg", 32'(wbWriteReg), 32'd6);
        chk("rel_memReq_drop", 32'(memReq), 32'h0);

        // Single-cycle IDLE vectors: non-memory ops, bubbles, misalignment, stray ack.
        for (int i = 0; i < 6; i++) begin
            exValid = iv[i].ex; ALUResult = iv[i].alu; MemRead = iv[i].rd; MemWrite = iv[i].wr;
            size = iv[i].sz; RegWrite = iv[i].rw; writeReg = iv[i].wreg; MemToReg = iv[i].m2r;
            memAck = iv[i].ack; storeData = 32'hFFFF_FFFF;
            #1;
            chk($sformatf("iv%0d_stall", i), 32'(stallMem), 32'h0);
            tick();
            chk($sformatf("iv%0d_wbValid", i), 32'(wbValid), 32'(iv[i].eValid));
            chk($sformatf("iv%0d_wbRegWrite", i), 32'(wbRegWrite), 32'(iv[i].eRegWrite));
            chk($sformatf("iv%0d_misalign", i), 32'(misalignErr), 32'(iv[i].eMis));
            chk($sformatf("iv%0d_memReq", i), 32'(memReq), 32'h0);
            if (iv[i].eFields) begin
                chk($sformatf("iv%0d_wbAlu", i), wbALUResult, iv[i].alu);
                chk($sformatf("iv%0d_wbWriteReg", i), 32'(wbWriteReg), 32'(iv[i].wreg));
                chk($sformatf("iv%0d_wbMemToReg", i), 32'(wbMemToReg), 32'(iv[i].m2r));
                chk($sformatf("iv%0d_wbData", i), wbDataMemOut, 32'h0);
            end
        end
        clearInputs();
        tick();
        chk("mis_pulse_end", 32'(misalignErr), 32'h0);

        // Aligned memory operations with varying ack delay.
        for (int i = 0; i < 10; i++) begin
            exValid = 1'b1; ALUResult = mv[i].alu; storeData = mv[i].sdata; MemRead = mv[i].rd;
            MemWrite = mv[i].wr; size = mv[i].sz; unsignedLoad = mv[i].uns; RegWrite = mv[i].rw;
            writeReg = 5'(i + 10); MemToReg = mv[i].rd; memAck = 1'b0;
            #1;
            chk($sformatf("mv%0d_setupStall", i), 32'(stallMem), 32'h1);
            tick();
            chk($sformatf("mv%0d_memReq", i), 32'(memReq), 32'h1);
            chk($sformatf("mv%0d_memAddr", i), memAddr, mv[i].eAddr);
            chk($sformatf("mv%0d_memWData", i), memWData, mv[i].eWData);
            chk($sformatf("mv%0d_memByteEn", i), 32'(memByteEn), 32'(mv[i].eBe));
            chk($sformatf("mv%0d_memWe", i), 32'(memWe), 32'(mv[i].eWe));
            chk($sformatf("mv%0d_wbBubble", i), 32'(wbValid), 32'h0);
            for (int k = 0; k < int'(mv[i].dly); k++) begin
                #1;
                chk($sformatf("mv%0d_waitStall%0d", i, k), 32'(stallMem), 32'h1);
                tick();
                chk($sformatf("mv%0d_holdReq%0d", i, k), 32'(memReq), 32'h1);
                chk($sformatf("mv%0d_holdAddr%0d", i, k), memAddr, mv[i].eAddr);
            end
            memAck = 1'b1; memRData = mv[i].rdata;
            #1;
            chk($sformatf("mv%0d_ackStall", i), 32'(stallMem), 32'h0);
            tick();
            clearInputs();
            chk($sformatf("mv%0d_reqDrop", i), 32'(memReq), 32'h0);
            chk($sformatf("mv%0d_wbValid", i), 32'(wbValid), 32'h1);
            chk($sformatf("mv%0d_wbData", i), wbDataMemOut, mv[i].eWb);
            chk($sformatf("mv%0d_wbRegWrite", i), 32'(wbRegWrite), 32'(mv[i].rw));
            chk($sformatf("mv%0d_wbAlu", i), wbALUResult, mv[i].alu);
            chk($sformatf("mv%0d_wbWriteReg", i), 32'(wbWriteReg), 32'(i + 10));
        end

        // Back-to-back loads with ack in the first ACCESS cycle, then reset mid-access.
        exValid = 1'b1; MemRead = 1'b1; RegWrite = 1'b1; size = 2'b10;
        ALUResult = 32'h0000_0800; writeReg = 5'd3;
        tick();
        chk("b2b_reqA", 32'(memReq), 32'h1);
        memAck = 1'b1; memRData = 32'hAAAA_5555;
        #1;
        chk("b2b_ackStallA", 32'(stallMem), 32'h0);
        tick();
        memAck = 1'b0; ALUResult = 32'h0000_0804; writeReg = 5'd4;
        #1;
        chk("b2b_gapReq", 32'(memReq), 32'h0);
        chk("b2b_issueStallB", 32'(stallMem), 32'h1);
        chk("b2b_wbDataA", wbDataMemOut, 32'hAAAA_5555);
        chk("b2b_wbValidA", 32'(wbValid), 32'h1);
        tick();
        chk("b2b_reqB", 32'(memReq), 32'h1);
        chk("b2b_addrB", memAddr, 32'h0000_0804);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_memReq", 32'(memReq), 32'h0);
        chk("midrst_stall", 32'(stallMem), 32'h0);
        chk("midrst_wbValid", 32'(wbValid), 32'h0);
        tick();
        clearInputs();
        rst_n = 1'b1;
        memAck = 1'b1; memRData = 32'h7777_7777;
        tick();
        memAck = 1'b0;
        chk("postrst_memReq", 32'(memReq), 32'h0);
        chk("postrst_wbValid", 32'(wbValid), 32'h0);
        chk("postrst_wbData", wbDataMemOut, 32'h0);
        exValid = 1'b1; RegWrite = 1'b1; ALUResult = 32'h0000_0099; writeReg = 5'd8;
        tick();
        chk("postrst_nonmem_wbValid", 32'(wbValid), 32'h1);
        chk("postrst_nonmem_wbAlu", wbALUResult, 32'h0000_0099);
        clearInputs();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule
